// File: rtl/clock_sequencer.sv
// clock_sequencer: run/halt/step controller issuing cycle -> ram -> internal phase strobes,
// with RAM wait-state stretching, wait timeout and a completed-instruction counter.
module clock_sequencer #(
    parameter int WAIT_MAX      = 15,
    parameter int CNT_W         = 32,
    parameter bit START_RUNNING = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic             step,
    input  logic             ram_busy,
    output logic             cycle_clock,
    output logic             ram_clock,
    output logic             internal_clock,
    output logic             halted,
    output logic             stall,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);
    typedef enum logic [1:0] {IDLE, RUN, STEP, DRAIN} state_t;
    typedef enum logic [1:0] {P0, P1, P2} phase_t;
    localparam logic [7:0] WMAX = 8'(WAIT_MAX);
    state_t     state, state_n;
    phase_t     ptr, ptr_n;
    logic [7:0] wait_cnt, wait_n;
    logic       active, at_p2, fin, expire, waiting;
    logic       cyc_n, ram_n, int_n, stall_n, timeout_n;
    assign active  = state != IDLE;
    assign at_p2   = active && ptr == P2;
    assign fin     = at_p2 && !ram_busy;
    assign expire  = at_p2 && ram_busy && wait_cnt == WMAX;
    assign waiting = at_p2 && ram_busy && !expire;
    // A halt seen mid-stall moves RUN to DRAIN so the stall resolves before halting.
    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = halt_req ? IDLE : run ? RUN : step ? STEP : IDLE;
        else if (expire)
            state_n = IDLE;
        else if (state == RUN && halt_req)
            state_n = fin ? IDLE : DRAIN;
        else if (state != RUN && fin)
            state_n = IDLE;
        ptr_n     = !active ? P0 : ptr == P0 ? P1 : ptr == P1 ? P2 : (fin || expire) ? P0 : P2;
        wait_n    = waiting ? wait_cnt + 8'd1 : 8'd0;
        cyc_n     = active && ptr == P0;
        ram_n     = active && ptr == P1;
        int_n     = fin;
        stall_n   = waiting;
        timeout_n = expire ? 1'b1 : (state == IDLE && !halt_req && run) ? 1'b0 : timeout;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= START_RUNNING ? RUN : IDLE;
            ptr            <= P0;
            wait_cnt       <= 8'd0;
            cycle_clock    <= 1'b0;
            ram_clock      <= 1'b0;
            internal_clock <= 1'b0;
            halted         <= !START_RUNNING;
            stall          <= 1'b0;
            timeout        <= 1'b0;
            cycle_count    <= '0;
        end else begin
            state          <= state_n;
            ptr            <= ptr_n;
            wait_cnt       <= wait_n;
            cycle_clock    <= cyc_n;
            ram_clock      <= ram_n;
            internal_clock <= int_n;
            halted         <= state_n == IDLE;
            stall          <= stall_n;
            timeout        <= timeout_n;
            cycle_count    <= cycle_count + CNT_W'(int_n);
        end
    end
endmodule

// File: tb/tb_clock_sequencer.sv
// tb_clock_sequencer: directed stimulus with a queue scoreboard for two sequencer configurations.
module tb_clock_sequencer;
    typedef struct packed {
        logic [2:0]  s;
        logic        h;
        logic        st;
        logic        to;
        logic [31:0] c;
    } rec_t;

    logic clk = 1'b0, reset = 1'b0;
    logic run_a = 1'b0, halt_a = 1'b0, step_a = 1'b0, busy_a = 1'b0;
    logic run_b = 1'b0, halt_b = 1'b0, step_b = 1'b0, busy_b = 1'b0;
    logic cyc_a, ram_a, int_a, halted_a, stall_a, to_a;
    logic cyc_b, ram_b, int_b, halted_b, stall_b, to_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;
    int vectors = 0, miscompares = 0;
    rec_t qa[$], qb[$];

    always #5 clk = ~clk;

    clock_sequencer #(.WAIT_MAX(15), .CNT_W(32), .START_RUNNING(1'b0)) dut_a (
        .clk(clk), .reset(reset), .run(run_a), .halt_req(halt_a), .step(step_a), .ram_busy(busy_a),
        .cycle_clock(cyc_a), .ram_clock(ram_a), .internal_clock(int_a), .halted(halted_a),
        .stall(stall_a), .timeout(to_a), .cycle_count(cnt_a));

    clock_sequencer #(.WAIT_MAX(3), .CNT_W(4), .START_RUNNING(1'b0)) dut_b (
        .clk(clk), .reset(reset), .run(run_b), .halt_req(halt_b), .step(step_b), .ram_busy(busy_b),
        .cycle_clock(cyc_b), .ram_clock(ram_b), .internal_clock(int_b), .halted(halted_b),
        .stall(stall_b), .timeout(to_b), .cycle_count(cnt_b));

    task automatic check(input string name, input logic [37:0] got, input logic [37:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic instr_a(input int c, input logic h);
        qa.push_back({3'b100, 1'b0, 1'b0, 1'b0, 32'(c)});
        qa.push_back({3'b010, 1'b0, 1'b0, 1'b0, 32'(c)});
        qa.push_back({3'b001, h, 1'b0, 1'b0, 32'(c + 1)});
    endtask

    task automatic instr_b(input int c, input logic h);
        qb.push_back({3'b100, 1'b0, 1'b0, 1'b0, 32'(c % 16)});
        qb.push_back({3'b010, 1'b0, 1'b0, 1'b0, 32'(c % 16)});
        qb.push_back({3'b001, h, 1'b0, 1'b0, 32'((c + 1) % 16)});
    endtask

    task automatic stall_a_exp(input int c, input int n);
        repeat (n) qa.push_back({3'b000, 1'b0, 1'b1, 1'b0, 32'(c)});
    endtask

    // Every clock with a strobe or stall must match the next expected record.
    always @(negedge clk) begin
        rec_t ga, gb;
        ga = {cyc_a, ram_a, int_a, halted_a, stall_a, to_a, cnt_a};
        gb = {cyc_b, ram_b, int_b, halted_b, stall_b, to_b, 28'd0, cnt_b};
        if (reset && (ga.s != 3'b000 || ga.st))
            check(qa.size() == 0 ? "a_unexpected" : "a_event", ga, qa.size() == 0 ? 38'd0 : qa.pop_front());
        if (reset && (gb.s != 3'b000 || gb.st))
            check(qb.size() == 0 ? "b_unexpected" : "b_event", gb, qb.size() == 0 ? 38'd0 : qb.pop_front());
    end

    initial begin
        tick(3);
        check("reset_a", {cyc_a, ram_a, int_a, halted_a, stall_a, to_a, cnt_a}, {6'b000100, 32'd0});
        check("reset_b", {cyc_b, ram_b, int_b, halted_b, stall_b, to_b, 28'd0, cnt_b}, {6'b000100, 32'd0});
        reset = 1'b1;
        tick(10);
        check("idle_halted_a", 38'(halted_a), 38'(1));

        for (int i = 0; i < 11; i++) instr_a(i, i == 10);
        qa.delete(qa.size() - 1);
        qa.push_back({3'b001, 1'b1, 1'b0, 1'b0, 32'd11});
        run_a = 1'b1;
        tick(1);
        run_a = 1'b0;
        tick(30);
        check("count_after_30", 38'(cnt_a), 38'(10));
        tick(1);
        halt_a = 1'b1;
        tick(7);
        halt_a = 1'b0;
        check("drain_halted", 38'({halted_a, cnt_a}), {5'd0, 1'b1, 32'd11});

        instr_a(11, 1'b0);
        instr_a(12, 1'b1);
        run_a = 1'b1;
        step_a = 1'b1;
        tick(1);
        run_a = 1'b0;
        step_a = 1'b0;
        tick(3);
        halt_a = 1'b1;
        tick(3);
        halt_a = 1'b0;
        tick(2);
        check("run_wins_halted", 38'({halted_a, cnt_a}), {5'd0, 1'b1, 32'd13});

        instr_a(13, 1'b1);
        step_a = 1'b1;
        tick(1);
        step_a = 1'b0;
        tick(6);
        check("step_done", 38'({halted_a, cnt_a}), {5'd0, 1'b1, 32'd14});

        qa.push_back({3'b100, 1'b0, 1'b0, 1'b0, 32'd14});
        qa.push_back({3'b010, 1'b0, 1'b0, 1'b0, 32'd14});
        stall_a_exp(14, 4);
        qa.push_back({3'b001, 1'b0, 1'b0, 1'b0, 32'd15});
        instr_a(15, 1'b1);
        run_a = 1'b1;
        tick(1);
        run_a = 1'b0;
        tick(2);
        busy_a = 1'b1;
        tick(4);
        busy_a = 1'b0;
        tick(3);
        halt_a = 1'b1;
        tick(1);
        halt_a = 1'b0;
        check("wait_no_timeout", 38'({halted_a, to_a, cnt_a}), {4'd0, 2'b10, 32'd16});
        tick(2);

        qa.push_back({3'b100, 1'b0, 1'b0, 1'b0, 32'd16});
        qa.push_back({3'b010, 1'b0, 1'b0, 1'b0, 32'd16});
        stall_a_exp(16, 2);
        qa.push_back({3'b001, 1'b1, 1'b0, 1'b0, 32'd17});
        run_a = 1'b1;
        tick(1);
        run_a = 1'b0;
        tick(2);
        busy_a = 1'b1;
        halt_a = 1'b1;
        tick(2);
        busy_a = 1'b0;
        tick(1);
        halt_a = 1'b0;
        tick(3);
        check("halt_after_stall", 38'({halted_a, cnt_a}), {5'd0, 1'b1, 32'd17});

        qb.push_back({3'b100, 1'b0, 1'b0, 1'b0, 32'd0});
        qb.push_back({3'b010, 1'b0, 1'b0, 1'b0, 32'd0});
        repeat (3) qb.push_back({3'b000, 1'b0, 1'b1, 1'b0, 32'd0});
        run_b = 1'b1;
        tick(1);
        run_b = 1'b0;
        tick(2);
        busy_b = 1'b1;
        tick(4);
        check("timeout_set", 38'({halted_b, stall_b, to_b, cnt_b}), {31'd0, 3'b101, 4'd0});
        busy_b = 1'b0;
        tick(2);

        for (int i = 0; i < 17; i++) instr_b(i, i == 16);
        run_b = 1'b1;
        tick(1);
        run_b = 1'b0;
        check("timeout_clear", 38'({halted_b, to_b}), 38'(0));
        tick(50);
        halt_b = 1'b1;
        tick(1);
        halt_b = 1'b0;
        tick(3);
        check("count_wrap", 38'({halted_b, cnt_b}), {33'd0, 1'b1, 4'd1});

        tick(3);
        check("queue_a_drained", 38'(qa.size()), 38'(0));
        check("queue_b_drained", 38'(qb.size()), 38'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
